// File: rtl/axi4_frame_writer.sv
// AXI4 write master: buffers packed pixel words and stores them in the DDR frame
// buffer as fixed-length INCR bursts, wrapping to the base address every frame.
module axi4_frame_writer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h0100_0000,
  parameter int BURST_LEN = 64,
  parameter int BURSTS_PER_FRAME = 300,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                        clk_100Mhz,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic [AXI_DATA_WIDTH-1:0]   s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic [3:0]                  AWCACHE,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  output logic                        WLAST,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic                        frame_done,
  output logic [7:0]                  bresp_err_cnt,
  output logic                        overflow,
  output logic [7:0]                  fifo_level
);

  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int LVL_W          = PTR_W + 1;
  localparam int IDX_W          = $clog2(BURSTS_PER_FRAME);
  localparam int BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;

  localparam logic [LVL_W-1:0]          LEVEL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]          LEVEL_BURST = LVL_W'(BURST_LEN);
  localparam logic [7:0]                BEAT_LAST   = 8'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]          LAST_BURST  = IDX_W'(BURSTS_PER_FRAME - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);
  localparam logic [2:0]                SIZE_CODE   = 3'($clog2(BYTES_PER_BEAT));

  typedef enum logic [1:0] {IDLE, ADDR_SEND, DATA_WRITE, RESP_WAIT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [LVL_W-1:0]          level;
  logic                      push, pop;

  state_t                    state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] offset, offset_nx;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_nx;
  logic [IDX_W-1:0]          burst_idx, burst_idx_nx;
  logic [7:0]                beat_cnt, beat_cnt_nx;
  logic [7:0]                err_cnt_nx;
  logic                      aw_valid_nx, w_valid_nx, b_ready_nx, frame_done_nx;
  logic                      pending, pending_nx;

  assign AWLEN   = BEAT_LAST;
  assign AWSIZE  = SIZE_CODE;
  assign AWBURST = 2'b01;
  assign AWCACHE = 4'b1111;
  assign WSTRB   = '1;

  // Input FIFO: first-word fall-through, head word drives WDATA directly
  assign s_ready    = (level != LEVEL_FULL);
  assign push       = s_valid && s_ready;
  assign pop        = WVALID && WREADY;
  assign WDATA      = mem[rd_ptr];
  assign fifo_level = 8'(level);

  always_ff @(posedge clk_100Mhz) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (s_valid && !s_ready) overflow <= 1'b1;
    end
  end

  // Burst sequencer: AW, then 64 W beats, then one B response, strictly in order
  assign WLAST = (state == DATA_WRITE) && (beat_cnt == BEAT_LAST);

  always_comb begin
    state_nx      = state;
    aw_addr_nx    = AWADDR;
    aw_valid_nx   = AWVALID;
    w_valid_nx    = WVALID;
    b_ready_nx    = BREADY;
    frame_done_nx = 1'b0;
    err_cnt_nx    = bresp_err_cnt;
    offset_nx     = offset;
    burst_idx_nx  = burst_idx;
    beat_cnt_nx   = beat_cnt;
    pending_nx    = pending;

    case (state)
      IDLE: begin
        // A restart request is folded in before the next address is formed
        if (frame_start || pending) begin
          offset_nx    = '0;
          burst_idx_nx = '0;
          pending_nx   = 1'b0;
        end
        if (level >= LEVEL_BURST) begin
          aw_addr_nx  = FRAME_BASE_ADDR + offset_nx;
          aw_valid_nx = 1'b1;
          state_nx    = ADDR_SEND;
        end
      end
      ADDR_SEND: begin
        if (AWREADY) begin
          aw_valid_nx = 1'b0;
          w_valid_nx  = 1'b1;
          state_nx    = DATA_WRITE;
        end
      end
      DATA_WRITE: begin
        if (WREADY) begin
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt_nx = '0;
            w_valid_nx  = 1'b0;
            b_ready_nx  = 1'b1;
            state_nx    = RESP_WAIT;
          end else begin
            beat_cnt_nx = beat_cnt + 8'd1;
          end
        end
      end
      RESP_WAIT: begin
        if (BVALID && BREADY) begin
          b_ready_nx = 1'b0;
          if (BRESP != 2'b00) err_cnt_nx = sat_inc(bresp_err_cnt);
          if (burst_idx == LAST_BURST) begin
            offset_nx     = '0;
            burst_idx_nx  = '0;
            frame_done_nx = 1'b1;
          end else begin
            offset_nx    = offset + BURST_BYTES;
            burst_idx_nx = burst_idx + 1'b1;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (frame_start && (state != IDLE)) pending_nx = 1'b1;
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      AWADDR        <= FRAME_BASE_ADDR;
      AWVALID       <= 1'b0;
      WVALID        <= 1'b0;
      BREADY        <= 1'b0;
      frame_done    <= 1'b0;
      bresp_err_cnt <= 8'd0;
      offset        <= '0;
      burst_idx     <= '0;
      beat_cnt      <= 8'd0;
      pending       <= 1'b0;
    end else begin
      state         <= state_nx;
      AWADDR        <= aw_addr_nx;
      AWVALID       <= aw_valid_nx;
      WVALID        <= w_valid_nx;
      BREADY        <= b_ready_nx;
      frame_done    <= frame_done_nx;
      bresp_err_cnt <= err_cnt_nx;
      offset        <= offset_nx;
      burst_idx     <= burst_idx_nx;
      beat_cnt      <= beat_cnt_nx;
      pending       <= pending_nx;
    end
  end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Directed bench for axi4_frame_writer: AXI slave model with optional stalls,
// a word scoreboard, and hand-computed burst addresses and counters.
module tb_axi4_frame_writer;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk_100Mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        WLAST;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic        frame_done;
  logic [7:0]  bresp_err_cnt;
  logic        overflow;
  logic [7:0]  fifo_level;

  always #5 clk_100Mhz = ~clk_100Mhz;

  axi4_frame_writer dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .frame_start(frame_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .frame_done(frame_done), .bresp_err_cnt(bresp_err_cnt),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [63:0] exp_q[$];
  logic [31:0] aw_q[$];
  logic [63:0] next_word = '0;
  bit          stall_aw = 0, stall_w = 0, wready_low = 0;
  int          beat = 0, b_cnt = 0, done_cnt = 0, done_at = -1, err_lo = 0, err_hi = 0;
  bit          b_pend = 0, aw_stall_prev = 0, w_stall_prev = 0;
  logic [31:0] awaddr_prev = '0;
  logic [63:0] wdata_prev = '0;

  // Slave model: decides readies for the coming edge and logs the handshakes it implies
  always @(negedge clk_100Mhz) begin
    if (!rst_n) begin
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      beat = 0; b_pend = 0; aw_stall_prev = 0; w_stall_prev = 0;
    end else begin
      if (aw_stall_prev) begin
        chk("aw_hold_valid", AWVALID, 1);
        chk("aw_hold_addr", AWADDR, awaddr_prev);
      end
      if (w_stall_prev) begin
        chk("w_hold_valid", WVALID, 1);
        chk("w_hold_data", WDATA, wdata_prev);
      end
      if (frame_done) begin done_cnt++; done_at = b_cnt; end
      BVALID = 1'b0; BRESP = 2'b00;
      if (b_pend && BREADY) begin
        BVALID = 1'b1;
        BRESP  = (b_cnt >= err_lo && b_cnt < err_hi) ? 2'b10 : 2'b00;
        b_cnt++; b_pend = 0;
      end
      AWREADY = stall_aw ? 1'($urandom_range(0, 1)) : 1'b1;
      WREADY  = wready_low ? 1'b0 : (stall_w ? 1'($urandom_range(0, 1)) : 1'b1);
      if (AWVALID && AWREADY) aw_q.push_back(AWADDR);
      if (WVALID && WREADY) begin
        chk("w_beat_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("wdata", WDATA, exp_q.pop_front());
        chk("wlast", WLAST, (beat == 63) ? 64'd1 : 64'd0);
        if (beat == 63) begin beat = 0; b_pend = 1; end
        else beat++;
      end
      aw_stall_prev = AWVALID && !AWREADY; awaddr_prev = AWADDR;
      w_stall_prev  = WVALID && !WREADY;   wdata_prev  = WDATA;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100Mhz);
  endtask

  task automatic push_words(input int n);
    int sent = 0;
    int g = 0;
    while (sent < n && g < 4 * n + 1000) begin
      if (s_ready) begin
        s_valid = 1'b1; s_data = next_word;
        exp_q.push_back(next_word);
        next_word++; sent++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk_100Mhz); g++;
    end
    s_valid = 1'b0;
    if (sent < n) chk("push_timeout", sent, n);
  endtask

  task automatic wait_b(input int target);
    int g = 0;
    while (b_cnt < target && g < 4000) begin @(negedge clk_100Mhz); g++; end
    if (b_cnt < target) chk("b_timeout", b_cnt, target);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, b0, g;
    rst_n = 1'b0;
    tick(3);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_cnt", bresp_err_cnt, 0);
    chk("rst_awaddr", AWADDR, BASE);
    chk("rst_level", fifo_level, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("awlen", AWLEN, 8'd63);
    chk("awsize", AWSIZE, 3'b011);
    chk("awburst", AWBURST, 2'b01);
    chk("awcache", AWCACHE, 4'b1111);
    chk("wstrb", WSTRB, 8'hFF);
    rst_n = 1'b1;
    tick(2);

    // single burst, words 0..63, no stalls
    push_words(64);
    chk("t1_level64", fifo_level, 64);
    chk("t1_awvalid_not_yet", AWVALID, 0);
    tick(1);
    chk("t1_awvalid", AWVALID, 1);
    chk("t1_awaddr", AWADDR, BASE);
    wait_b(1);
    chk("t1_aw_logged", aw_q[0], BASE);
    chk("t1_level_end", fifo_level, 0);
    chk("t1_scoreboard_empty", exp_q.size(), 0);
    chk("t1_no_frame_done", done_cnt, 0);

    // rest of the frame plus the first burst of the next frame
    push_words(300 * 64);
    wait_b(301);
    for (int k = 0; k <= 300; k++)
      chk($sformatf("t2_aw%0d", k), aw_q[k], BASE + 32'(512 * (k % 300)));
    chk("t2_burst300_addr", aw_q[299], 32'h0102_5600);
    chk("t2_burst301_addr", aw_q[300], BASE);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_after_b300", done_at, 300);
    chk("t2_scoreboard_empty", exp_q.size(), 0);

    // random AW/W stalls
    stall_aw = 1; stall_w = 1;
    b0 = b_cnt;
    push_words(192);
    wait_b(b0 + 3);
    stall_aw = 0; stall_w = 0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("t3_aw%0d", k), aw_q[301 + k], BASE + 32'(512 * (k + 1)));
    chk("t3_scoreboard_empty", exp_q.size(), 0);
    chk("t3_level_end", fifo_level, 0);

    // reset in the middle of the data phase
    push_words(64);
    g = 0;
    while (beat < 20 && g < 200) begin tick(1); g++; end
    chk("t4_reached_beat20", 64'(beat >= 20), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_wvalid_async", WVALID, 0);
    chk("t4_awvalid_async", AWVALID, 0);
    chk("t4_wlast_async", WLAST, 0);
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    tick(1);
    chk("t4_awaddr", AWADDR, BASE);
    chk("t4_level", fifo_level, 0);
    chk("t4_s_ready", s_ready, 1);

    // frame_start while burst 10 is in flight
    aw0 = aw_q.size();
    b0 = b_cnt;
    push_words(640);
    wait_b(b0 + 10);
    push_words(64);
    g = 0;
    while (!WVALID && g < 50) begin tick(1); g++; end
    chk("t5_in_burst10", WVALID, 1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    push_words(64);
    wait_b(b0 + 12);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t5_aw%0d", k), aw_q[aw0 + k], BASE + 32'(512 * k));
    chk("t5_burst10_addr", aw_q[aw0 + 10], 32'h0100_1400);
    chk("t5_restart_addr", aw_q[aw0 + 11], BASE);
    chk("t5_no_extra_done", done_cnt, 1);

    // three SLVERR responses, then one OKAY
    b0 = b_cnt;
    aw0 = aw_q.size();
    err_lo = b0; err_hi = b0 + 3;
    push_words(256);
    wait_b(b0 + 4);
    chk("t6_err_cnt", bresp_err_cnt, 3);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t6_aw%0d", k), aw_q[aw0 + k], BASE + 32'(512 * (k + 1)));

    // fill the FIFO with W blocked, then push against a full FIFO
    chk("t7_overflow_clear", overflow, 0);
    wready_low = 1;
    b0 = b_cnt;
    push_words(128);
    chk("t7_full_s_ready", s_ready, 0);
    chk("t7_full_level", fifo_level, 128);
    chk("t7_no_overflow_yet", overflow, 0);
    s_valid = 1'b1; s_data = 64'hBAD0_BAD0;
    tick(3);
    s_valid = 1'b0;
    tick(2);
    chk("t7_overflow_set", overflow, 1);
    chk("t7_level_held", fifo_level, 128);
    wready_low = 0;
    wait_b(b0 + 2);
    chk("t7_overflow_sticky", overflow, 1);
    chk("t7_level_drained", fifo_level, 0);
    chk("t7_scoreboard_empty", exp_q.size(), 0);
    chk("t7_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_frame_writer.md
Name: axi4_frame_writer

Overview:
AXI4 write master that packs incoming camera pixel words into 64-beat INCR bursts and stores them in the DDR frame buffer, from which the HDMI read path fetches. A single-clock internal FIFO absorbs producer stalls. The block walks 300 bursts per 320x240 RGB565 frame, then wraps to the base address.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, data width (4 pixels of 16 bit per word)
FRAME_BASE_ADDR, 32'h0100_0000, DDR frame start address
BURST_LEN, 64, beats per burst (AWLEN = BURST_LEN-1)
BURSTS_PER_FRAME, 300, bursts per frame (76800 px * 2 B / 512 B)
FIFO_DEPTH, 128, input buffer depth in words (power of 2, >= BURST_LEN)

Ports:
clk_100Mhz  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; restart the write pointer at FRAME_BASE_ADDR
s_data  in  64  packed pixel word
s_valid  in  1  s_data valid
s_ready  out  1  = !fifo_full
AWADDR  out  32  burst address
AWVALID  out  1
AWREADY  in  1
AWLEN  out  8  constant 8'd63
AWSIZE  out  3  constant 3'b011
AWBURST  out  2  constant 2'b01 (INCR)
AWCACHE  out  4  constant 4'b1111
WDATA  out  64  FIFO head word
WSTRB  out  8  constant 8'hFF
WVALID  out  1
WREADY  in  1
WLAST  out  1  high on beat 63
BRESP  in  2
BVALID  in  1
BREADY  out  1
frame_done  out  1  one-cycle pulse after the B response of the last burst of a frame
bresp_err_cnt  out  8  count of non-OKAY BRESP, saturating at 255
overflow  out  1  sticky flag: s_valid while full
fifo_level  out  8  current word count

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE. AWVALID, WVALID, WLAST, BREADY, frame_done, overflow and bresp_err_cnt = 0. AWADDR = FRAME_BASE_ADDR. Offset=0, burst_idx=0, beat_cnt=0. FIFO emptied. Reset mid-burst drops AWVALID/WVALID at once.
- FIFO: push on s_valid&&s_ready; pop on WVALID&&WREADY. Simultaneous push and pop leaves the level unchanged. WDATA = mem[rd_ptr] (first-word fall-through). Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: when fifo_level >= BURST_LEN, register AWADDR = FRAME_BASE_ADDR + offset and AWVALID=1, then go to ADDR_SEND. A pending frame_start is applied first in the same cycle: offset=0, burst_idx=0.
- ADDR_SEND: hold AWVALID and AWADDR stable until AWREADY. On the handshake, AWVALID=0 and go to DATA_WRITE.
- DATA_WRITE: WVALID=1 continuously (64 words are guaranteed buffered). beat_cnt increments on each handshake. WLAST = (beat_cnt==63). On the WLAST handshake: WVALID=0, beat_cnt=0, go to RESP_WAIT. WREADY low holds all W signals stable.
- RESP_WAIT: BREADY=1. On BVALID, BREADY=0.
  - If BRESP != 2'b00, increment bresp_err_cnt (saturating). Address advance is unaffected.
  - offset += 512 and burst_idx += 1.
  - If burst_idx was BURSTS_PER_FRAME-1: offset=0, burst_idx=0, frame_done=1 for one cycle.
  - Go to IDLE.
- frame_start arriving in any non-IDLE state sets a pending flag, and the current burst completes normally. If frame_start coincides with the end-of-frame wrap, the result is offset=0, frame_done still pulses, and the flag clears at the next IDLE.
- AW and W are serialized (no W before the AW handshake). One outstanding burst at most.
- Minimum burst issue latency: IDLE (level >= 64) to AWVALID high = 1 cycle.

Test Plan:
- Push 64 words 0..63, AWREADY/WREADY/BVALID always 1 -> AWVALID 1 cycle after level hits 64. AWADDR=0x0100_0000. 64 W beats with WDATA 0..63. WLAST only on beat 63. fifo_level ends at 0.
- Stream 300 bursts -> AWADDR of burst k = 0x0100_0000 + 512*k. frame_done pulses once after the 300th BVALID. Burst 301 uses 0x0100_0000.
- Random WREADY/AWREADY stalls (~50%) -> AWADDR/AWVALID/WDATA stable while stalled. No dropped or duplicated words versus a scoreboard.
- frame_start pulse during burst 10 -> burst 10 completes at 0x0100_1400. The next AWADDR is 0x0100_0000.
- BRESP=2'b10 on 3 bursts -> bresp_err_cnt=3. Addresses still advance by 512. Hold s_valid with WREADY=0 past 128 words -> s_ready=0 and overflow=1 stays set.
- Assert rst_n low mid DATA_WRITE (beat 20) -> WVALID=0 immediately. On release, AWADDR=0x0100_0000 and fifo_level=0.
